// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data-length encoding,
// parity type constants and small bit helpers reused by the UART TX.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        DATA_BITS_5 = 2'd0,
        DATA_BITS_6 = 2'd1,
        DATA_BITS_7 = 2'd2,
        DATA_BITS_8 = 2'd3
    } uart_data_bits_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Index of the last data bit for a given data length.
    function automatic logic [2:0] last_bit_idx(input uart_data_bits_e bits);
        case (bits)
            DATA_BITS_5: return 3'd4;
            DATA_BITS_6: return 3'd5;
            DATA_BITS_7: return 3'd6;
            DATA_BITS_8: return 3'd7;
            default:     return 3'd7;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit a transmitter sends for this data; unused upper bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input logic ptype);
        return (^data) ^ (ptype == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous input; flops reset to 1 so an
// idle-high line never produces a spurious edge out of reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_r;

    // Shift chain toward the MSB; MSB is the synchronised output.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_r <= {STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample voting, configurable frame format,
// error/break detection and a valid/ready holding register.
module uart_rx_ovs import uart_pkg::*; #(
    parameter int OSR         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic [1:0] cfg_data_bits_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_type_i,
    input  logic       cfg_stop_bits_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o,
    input  logic       rx_data_ready_i,
    output logic       int_parity_err_o,
    output logic       int_frame_err_o,
    output logic       int_break_o,
    output logic       int_overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OSR / 2);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(OSR / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    logic           rxs_s;
    logic           rxs_prev_r;
    uart_rx_state_e state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]     bit_idx_r;
    logic [2:0]     last_idx_r;
    logic           par_en_r;
    logic           par_type_r;
    logic           stop2_r;
    logic           par_bit_r;
    logic           samp0_r;
    logic           samp1_r;
    logic [7:0]     shift_r;
    logic           busy_r;
    logic           par_err_r;
    logic           frame_err_r;
    logic           break_r;
    logic           overrun_r;
    logic [7:0]     data_r;
    logic           valid_r;

    logic vote_s;
    logic decide_s;
    logic wrap_s;
    logic fall_s;
    logic par_bad_s;
    logic break_s;
    logic deliver_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d_i     (rx_i),
        .q_o     (rxs_s)
    );

    // Per-bit decisions shared by every state of the frame FSM.
    always_comb begin
        vote_s    = majority3(samp0_r, samp1_r, rxs_s);
        decide_s  = (cnt_r == CNT_VOTE);
        wrap_s    = (cnt_r == CNT_LAST);
        fall_s    = rxs_prev_r & ~rxs_s;
        par_bad_s = par_en_r & (par_bit_r != parity_bit(shift_r, par_type_r));
        break_s   = (shift_r == 8'h00) & ~(par_en_r & par_bit_r);
        deliver_s = decide_s & vote_s & ~par_bad_s &
                    (((state_r == ST_STOP1) & ~stop2_r) | (state_r == ST_STOP2));
    end

    // Frame FSM with sample counter, shift register and interrupt pulses.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r     <= ST_IDLE;
            rxs_prev_r  <= 1'b1;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            last_idx_r  <= 3'd7;
            par_en_r    <= 1'b0;
            par_type_r  <= 1'b0;
            stop2_r     <= 1'b0;
            par_bit_r   <= 1'b0;
            samp0_r     <= 1'b1;
            samp1_r     <= 1'b1;
            shift_r     <= 8'h00;
            busy_r      <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            break_r     <= 1'b0;
        end else begin
            rxs_prev_r  <= rxs_s;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            break_r     <= 1'b0;
            cnt_r       <= wrap_s ? '0 : cnt_r + CNT_ONE;
            if (cnt_r == CNT_S0) samp0_r <= rxs_s;
            if (cnt_r == CNT_S1) samp1_r <= rxs_s;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r    <= ST_START;
                        busy_r     <= 1'b1;
                        cnt_r      <= '0;
                        bit_idx_r  <= 3'd0;
                        shift_r    <= 8'h00;
                        par_bit_r  <= 1'b0;
                        last_idx_r <= last_bit_idx(uart_data_bits_e'(cfg_data_bits_i));
                        par_en_r   <= cfg_parity_en_i;
                        par_type_r <= cfg_parity_type_i;
                        stop2_r    <= cfg_stop_bits_i;
                    end
                end
                ST_START: begin
                    if (decide_s && vote_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (wrap_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide_s) shift_r[bit_idx_r] <= vote_s;
                    if (wrap_s) begin
                        if (bit_idx_r == last_idx_r) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= par_en_r ? ST_PARITY : ST_STOP1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_s) par_bit_r <= vote_s;
                    if (wrap_s) state_r <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (decide_s) begin
                        if (!vote_s) begin
                            // An all-zero frame with a low stop bit is a line break, not a framing fault.
                            if (break_s) begin
                                break_r <= 1'b1;
                                state_r <= ST_BREAK_WAIT;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= ST_IDLE;
                                busy_r      <= 1'b0;
                            end
                        end else if (!stop2_r) begin
                            par_err_r <= par_bad_s;
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                        end
                    end else if (wrap_s) begin
                        state_r <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (decide_s) begin
                        if (!vote_s) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            par_err_r <= par_bad_s;
                        end
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rxs_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: a full, un-acknowledged word is kept and the new one dropped.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (deliver_s) begin
                if (!valid_r || rx_data_ready_i) begin
                    data_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && rx_data_ready_i) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign rx_data_o        = data_r;
    assign rx_data_valid_o  = valid_r;
    assign int_parity_err_o = par_err_r;
    assign int_frame_err_o  = frame_err_r;
    assign int_break_o      = break_r;
    assign int_overrun_o    = overrun_r;
    assign busy_o           = busy_r;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: a table of frame formats plus hand-written
// glitch, overrun, break and mid-frame reset sequences.
module tb_uart_rx_ovs;

    localparam int OSR = 8;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic [1:0] cfg_data_bits_i;
    logic       cfg_parity_en_i;
    logic       cfg_parity_type_i;
    logic       cfg_stop_bits_i;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_data_valid_o;
    logic       rx_data_ready_i;
    logic       int_parity_err_o;
    logic       int_frame_err_o;
    logic       int_break_o;
    logic       int_overrun_o;
    logic       busy_o;

    uart_rx_ovs #(.OSR(OSR), .SYNC_STAGES(2)) dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .cfg_data_bits_i   (cfg_data_bits_i),
        .cfg_parity_en_i   (cfg_parity_en_i),
        .cfg_parity_type_i (cfg_parity_type_i),
        .cfg_stop_bits_i   (cfg_stop_bits_i),
        .rx_i              (rx_i),
        .rx_data_o         (rx_data_o),
        .rx_data_valid_o   (rx_data_valid_o),
        .rx_data_ready_i   (rx_data_ready_i),
        .int_parity_err_o  (int_parity_err_o),
        .int_frame_err_o   (int_frame_err_o),
        .int_break_o       (int_break_o),
        .int_overrun_o     (int_overrun_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;

    int n_valid = 0, n_par = 0, n_frame = 0, n_brk = 0, n_ovr = 0, n_busy = 0;
    int rise_cyc = 0, busy_rise_cyc = 0, ovr_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic valid_prev = 1'b0, busy_prev = 1'b0;

    int s_valid, s_par, s_frame, s_brk, s_ovr, s_busy;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rx_data_valid_o) begin
            n_valid++;
            last_data = rx_data_o;
        end
        if (rx_data_valid_o && !valid_prev) rise_cyc = cyc;
        if (busy_o) n_busy++;
        if (busy_o && !busy_prev) busy_rise_cyc = cyc;
        if (int_parity_err_o) n_par++;
        if (int_frame_err_o) n_frame++;
        if (int_break_o) n_brk++;
        if (int_overrun_o) begin
            n_ovr++;
            ovr_cyc = cyc;
        end
        valid_prev = rx_data_valid_o;
        busy_prev  = busy_o;
    end

    typedef struct {
        logic [7:0] d;
        logic [1:0] dbits;
        logic       pen;
        logic       ptype;
        logic       two;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic       scr;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_par;
        int         exp_frame;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic line(input logic b, input int n);
        rx_i = b;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pen, input logic pt, input logic two);
        cfg_data_bits_i   = db;
        cfg_parity_en_i   = pen;
        cfg_parity_type_i = pt;
        cfg_stop_bits_i   = two;
    endtask

    task automatic snap();
        s_valid = n_valid; s_par = n_par; s_frame = n_frame;
        s_brk = n_brk; s_ovr = n_ovr; s_busy = n_busy;
    endtask

    task automatic send(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                        input logic s1, input logic two, input logic s2, input int gap,
                        input logic scr);
        fall_cyc = cyc;
        line(1'b0, OSR);
        if (scr) set_cfg(2'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < nb; i++) line(d[i], OSR);
        if (pen) line(pbit, OSR);
        line(s1, OSR);
        if (two) line(s2, OSR);
        line(1'b1, gap);
    endtask

    initial begin
        //            d      dbits pen  ptype two  pbit s1   s2   scr  val data   par fr
        vecs[0]  = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
        vecs[1]  = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1, 0};
        vecs[2]  = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 0, 1};
        vecs[3]  = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'h1F, 0, 0};
        vecs[4]  = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h2A, 0, 0};
        vecs[5]  = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h00, 0, 0};
        vecs[6]  = '{8'hFF, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8'h7F, 0, 0};
        vecs[7]  = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 1};
        vecs[8]  = '{8'h81, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 1};
        vecs[9]  = '{8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'hC3, 0, 0};
        vecs[10] = '{8'h35, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h35, 0, 0};

        arst_ni = 1'b0;
        rx_i = 1'b1;
        rx_data_ready_i = 1'b1;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", rx_data_o, 0);
        chk("rst_valid", rx_data_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_irq", {int_parity_err_o, int_frame_err_o, int_break_o, int_overrun_o}, 0);
        arst_ni = 1'b1;
        line(1'b1, 4);

        for (int i = 0; i < 11; i++) begin
            set_cfg(vecs[i].dbits, vecs[i].pen, vecs[i].ptype, vecs[i].two);
            snap();
            send(vecs[i].d, int'(vecs[i].dbits) + 5, vecs[i].pen, vecs[i].pbit,
                 vecs[i].s1, vecs[i].two, vecs[i].s2, 3 * OSR, vecs[i].scr);
            chk($sformatf("v%0d_valid", i), n_valid - s_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_par", i), n_par - s_par, vecs[i].exp_par);
            chk($sformatf("v%0d_frame", i), n_frame - s_frame, vecs[i].exp_frame);
            chk($sformatf("v%0d_brk_ovr", i), (n_brk - s_brk) + (n_ovr - s_ovr), 0);
            chk($sformatf("v%0d_busy", i), busy_o, 0);
            if (vecs[i].exp_valid != 0)
                chk($sformatf("v%0d_data", i), last_data, vecs[i].exp_data);
            if (i == 0)
                chk("v0_latency", rise_cyc - fall_cyc, 81);
        end

        // Start-bit glitch of two clocks.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        snap();
        fall_cyc = cyc;
        line(1'b0, 2);
        line(1'b1, 3 * OSR);
        chk("glitch_busy_rise", busy_rise_cyc - fall_cyc, 3);
        chk("glitch_busy_len", n_busy - s_busy, OSR / 2 + 2);
        chk("glitch_out", (n_valid - s_valid) + (n_par - s_par) + (n_frame - s_frame) +
                          (n_brk - s_brk) + (n_ovr - s_ovr), 0);

        // Back-to-back frames with the consumer stalled.
        rx_data_ready_i = 1'b0;
        snap();
        send(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        send(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3 * OSR, 1'b0);
        chk("b2b_ovr_cnt", n_ovr - s_ovr, 1);
        chk("b2b_ovr_time", ovr_cyc - fall_cyc, 81);
        chk("b2b_held_data", rx_data_o, 8'h11);
        chk("b2b_held_valid", rx_data_valid_o, 1);
        rx_data_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("b2b_valid_drop", rx_data_valid_o, 0);

        // Line held low for 12 bit times in 8E1, then a normal frame.
        set_cfg(2'd3, 1'b1, 1'b0, 1'b0);
        snap();
        line(1'b0, 12 * OSR);
        chk("brk_cnt", n_brk - s_brk, 1);
        chk("brk_busy_held", busy_o, 1);
        chk("brk_other", (n_frame - s_frame) + (n_par - s_par) + (n_valid - s_valid), 0);
        line(1'b1, 6);
        chk("brk_busy_drop", busy_o, 0);
        send(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3 * OSR, 1'b0);
        chk("brk_next_data", last_data, 8'h5A);
        chk("brk_next_valid", n_valid - s_valid, 1);
        chk("brk_single", n_brk - s_brk, 1);

        // Reset in the middle of a frame with a word pending.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        rx_data_ready_i = 1'b0;
        send(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3 * OSR, 1'b0);
        chk("mid_pending", rx_data_valid_o, 1);
        line(1'b0, 3 * OSR);
        arst_ni = 1'b0;
        #2;
        chk("mid_rst_valid", rx_data_valid_o, 0);
        chk("mid_rst_data", rx_data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        line(1'b1, 2);
        arst_ni = 1'b1;
        line(1'b1, 4);
        rx_data_ready_i = 1'b1;
        snap();
        send(8'h99, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3 * OSR, 1'b0);
        chk("post_rst_data", last_data, 8'h99);
        chk("post_rst_valid", n_valid - s_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
